db4_lattice_par: RTL and testbench

//  Parametrised Daubechies-4 two-channel analysis filter in lattice form, next generation of our

---
 rtl/db4_lattice_par.sv | 124 ++++++++++++
 tb/tb_db4_lattice_par.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/db4_lattice_par.sv
// rtl/db4_lattice_par.sv - Daubechies-4 two-channel lattice analysis filter, 3-stage pipeline
// Optional DB4_SAT_EN: rounded, saturated g/h instead of floor-and-wrap.
module db4_lattice_par #(
  parameter int W  = 8,
  parameter int IW = W + 9,
  parameter int OW = W + 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic signed [W-1:0]  x_in,
  input  logic                 in_valid,
  input  logic                 sync,
  output logic signed [OW-1:0] g,
  output logic signed [OW-1:0] h,
  output logic                 out_valid,
  output logic                 phase
);

  typedef enum logic {EVEN = 1'b0, ODD = 1'b1} phase_e;

  phase_e               phase_q;
  logic signed [W-1:0]  x_hold_q;
  logic                 fire;

  logic                 s1_v_q, s2_v_q, out_valid_q;
  logic signed [IW-1:0] sx_low_q, sx_up_q;
  logic signed [IW-1:0] up0_q, low0_q, up0_d, low0_d;
  logic signed [OW-1:0] g_q, h_q, g_d, h_d;

  // s = 124/256; the /256 is folded into the final >>> 8 of stage 3
  function automatic logic signed [IW-1:0] scale(input logic signed [W-1:0] x);
    logic signed [IW-1:0] v;
    v = {{(IW-W){x[W-1]}}, x};
    return (v <<< 7) - (v <<< 2);
  endfunction

  function automatic logic signed [IW-1:0] m0(input logic signed [IW-1:0] v);
    return ((v <<< 1) - (v >>> 2)) - ((v >>> 6) + (v >>> 8));
  endfunction

  function automatic logic signed [IW-1:0] m1(input logic signed [IW-1:0] v);
    return (v >>> 2) + (v >>> 6) + (v >>> 8);
  endfunction

`ifdef DB4_SAT_EN
  localparam logic signed [IW-1:0] RND  = IW'(128);
  localparam logic signed [IW-1:0] OMAX = IW'((1 << (OW-1)) - 1);
  localparam logic signed [IW-1:0] OMIN = -OMAX - IW'(1);

  function automatic logic signed [OW-1:0] fin(input logic signed [IW-1:0] v);
    logic signed [IW-1:0] r;
    r = (v + RND) >>> 8;
    if (r > OMAX) return OW'(OMAX);
    if (r < OMIN) return OW'(OMIN);
    return OW'(r);
  endfunction
`else
  function automatic logic signed [OW-1:0] fin(input logic signed [IW-1:0] v);
    return OW'(v >>> 8);
  endfunction
`endif

  // sync with a valid sample restarts the pair, so it never fires one
  assign fire = in_valid && !sync && (phase_q == ODD);

  always_ff @(posedge clk) begin
    if (!reset) begin
      phase_q  <= EVEN;
      x_hold_q <= '0;
    end else if (in_valid) begin
      if (sync || phase_q == EVEN) begin
        x_hold_q <= x_in;
        phase_q  <= ODD;
      end else begin
        phase_q  <= EVEN;
      end
    end else if (sync) begin
      phase_q <= EVEN;
    end
  end

  always_comb begin
    up0_d  = m0(sx_low_q) + sx_up_q;
    low0_d = sx_low_q - m0(sx_up_q);
    g_d    = fin(up0_q - m1(low0_q));
    h_d    = fin(low0_q + m1(up0_q));
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      s1_v_q      <= 1'b0;
      s2_v_q      <= 1'b0;
      out_valid_q <= 1'b0;
      sx_low_q    <= '0;
      sx_up_q     <= '0;
      up0_q       <= '0;
      low0_q      <= '0;
      g_q         <= '0;
      h_q         <= '0;
    end else begin
      s1_v_q <= fire;
      if (fire) begin
        sx_low_q <= scale(x_hold_q);
        sx_up_q  <= scale(x_in);
      end
      s2_v_q <= s1_v_q;
      if (s1_v_q) begin
        up0_q  <= up0_d;
        low0_q <= low0_d;
      end
      out_valid_q <= s2_v_q;
      if (s2_v_q) begin
        g_q <= g_d;
        h_q <= h_d;
      end
    end
  end

  assign g         = g_q;
  assign h         = h_q;
  assign out_valid = out_valid_q;
  assign phase     = phase_q;

endmodule

// File: tb/tb_db4_lattice_par.sv
// tb/tb_db4_lattice_par.sv - directed-vector bench for db4_lattice_par (W=8)
// Expected g/h are hand-derived from the shift-add lattice; DB4_SAT_EN widens g/h tolerance to 1 LSB.
module tb_db4_lattice_par;

  localparam int W  = 8;
  localparam int OW = W + 1;
`ifdef DB4_SAT_EN
  localparam int GH_TOL = 1;
`else
  localparam int GH_TOL = 0;
`endif

  logic                 clk = 1'b0;
  logic                 reset;
  logic signed [W-1:0]  x_in;
  logic                 in_valid;
  logic                 sync;
  logic signed [OW-1:0] g;
  logic signed [OW-1:0] h;
  logic                 out_valid;
  logic                 phase;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int last_pc = 0;
  int gq[$];
  int hq[$];
  int tq[$];
  int pcq[$];

  db4_lattice_par #(.W(W)) dut (
    .clk(clk), .reset(reset), .x_in(x_in), .in_valid(in_valid), .sync(sync),
    .g(g), .h(h), .out_valid(out_valid), .phase(phase)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (out_valid) begin
      gq.push_back(int'(g));
      hq.push_back(int'(h));
      tq.push_back(cyc);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input int obs, input int exp, input int tol = 0);
    n_tests++;
    if (obs > exp + tol || obs < exp - tol) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (tol %0d)", tag, obs, exp, tol);
    end
  endtask

  task automatic send(input int x, input bit v, input bit s);
    x_in     = x[W-1:0];
    in_valid = v;
    sync     = s;
    last_pc  = cyc;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    sync     = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) send(0, 1'b0, 1'b0);
  endtask

  task automatic check_outs(input string tag, input int n_exp, input int g_exp, input int h_exp);
    chk({tag, "_count"}, gq.size(), n_exp);
    foreach (gq[i]) begin
      if (i < n_exp) begin
        chk({tag, "_g"}, gq[i], g_exp, GH_TOL);
        chk({tag, "_h"}, hq[i], h_exp, GH_TOL);
      end
    end
    gq.delete();
    hq.delete();
    tq.delete();
  endtask

  initial begin
    int sent;
    int guard;
    bit v;

    reset = 1'b0; x_in = '0; in_valid = 1'b0; sync = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_g", int'(g), 0);
    chk("rst_h", int'(h), 0);
    chk("rst_ov", int'(out_valid), 0);
    chk("rst_phase", int'(phase), 0);
    reset = 1'b1;
    idle(2);

    // DC: back-to-back pairs, pipeline fully occupied
    repeat (8) send(100, 1'b1, 1'b0);
    idle(5);
    check_outs("dc", 4, 141, 0);

    // Nyquist with latency tracking
    pcq.delete();
    for (int i = 0; i < 3; i++) begin
      send(100, 1'b1, 1'b0);
      send(-100, 1'b1, 1'b0);
      pcq.push_back(last_pc);
      if (i == 1) idle(2);
    end
    idle(5);
    chk("nyq_lat_count", tq.size(), 3);
    foreach (tq[i]) if (i < pcq.size()) chk("nyq_latency", tq[i] - pcq[i], 3);
    check_outs("nyq", 3, -1, 141);

    // Gapped DC stream
    sent = 0;
    guard = 0;
    while (sent < 16 && guard < 400) begin
      v = ($urandom_range(0, 99) < 30);
      send(100, v, 1'b0);
      if (v) sent++;
      guard++;
    end
    chk("gap_sent", sent, 16);
    idle(5);
    check_outs("gap", 8, 141, 0);

    // sync with a valid sample: first 100 dropped, pair is (100,-100)
    chk("sync_ph0", int'(phase), 0);
    send(100, 1'b1, 1'b0);
    chk("sync_ph1", int'(phase), 1);
    send(100, 1'b1, 1'b1);
    chk("sync_ph2", int'(phase), 1);
    send(-100, 1'b1, 1'b0);
    idle(5);
    check_outs("sync_v", 1, -1, 141);

    // sync alone drops the pending even sample
    send(100, 1'b1, 1'b0);
    send(0, 1'b0, 1'b1);
    chk("sync_alone_ph", int'(phase), 0);
    send(100, 1'b1, 1'b0);
    send(-100, 1'b1, 1'b0);
    idle(5);
    check_outs("sync_alone", 1, -1, 141);

    // Reset while a pair is in flight
    send(100, 1'b1, 1'b0);
    send(-100, 1'b1, 1'b0);
    reset = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b1;
    chk("midrst_g", int'(g), 0);
    chk("midrst_h", int'(h), 0);
    chk("midrst_phase", int'(phase), 0);
    idle(6);
    chk("midrst_no_ov", gq.size(), 0);
    gq.delete(); hq.delete(); tq.delete();

    // Extremes
    repeat (4) send(-128, 1'b1, 1'b0);
    idle(5);
    check_outs("neg_dc", 2, -182, -1);
    repeat (2) begin
      send(-128, 1'b1, 1'b0);
      send(127, 1'b1, 1'b0);
    end
    idle(5);
    check_outs("alt_ext", 2, -1, -181);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
